// File: rtl/pipe_stage_elastic_pkg.sv
// rtl/pipe_stage_elastic_pkg.sv - shared encodings for the elastic pipeline stage and ID/EX payload layout
package pipe_stage_elastic_pkg;

    // Occupancy doubles as the stage state encoding.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // NOP encodings shared with the decoder.
    localparam logic [7:0]  EXE_NOP_OP     = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP    = 3'b000;
    localparam logic [4:0]  NOPRegAddr     = 5'b00000;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic        WriteDisable   = 1'b0;

    // Delay-slot flags.
    localparam logic        InDelaySlot    = 1'b1;
    localparam logic        NotInDelaySlot = 1'b0;

    // ID/EX payload field widths.
    localparam int IDEX_ALUOP_W  = 8;
    localparam int IDEX_ALUSEL_W = 3;
    localparam int IDEX_REG_W    = 32;
    localparam int IDEX_WD_W     = 5;
    localparam int IDEX_WREG_W   = 1;
    localparam int IDEX_LINK_W   = 32;
    localparam int IDEX_DS_W     = 1;

    // ID/EX payload field offsets (LSB of each field), packed from in_delayslot upward.
    localparam int IDEX_DS_LSB     = 0;
    localparam int IDEX_LINK_LSB   = IDEX_DS_LSB     + IDEX_DS_W;
    localparam int IDEX_WREG_LSB   = IDEX_LINK_LSB   + IDEX_LINK_W;
    localparam int IDEX_WD_LSB     = IDEX_WREG_LSB   + IDEX_WREG_W;
    localparam int IDEX_REG2_LSB   = IDEX_WD_LSB     + IDEX_WD_W;
    localparam int IDEX_REG1_LSB   = IDEX_REG2_LSB   + IDEX_REG_W;
    localparam int IDEX_ALUSEL_LSB = IDEX_REG1_LSB   + IDEX_REG_W;
    localparam int IDEX_ALUOP_LSB  = IDEX_ALUSEL_LSB + IDEX_ALUSEL_W;
    localparam int IDEX_W          = IDEX_ALUOP_LSB  + IDEX_ALUOP_W;

    localparam logic [IDEX_W-1:0] IDEX_NOP = {EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord,
                                              NOPRegAddr, WriteDisable, ZeroWord, NotInDelaySlot};

endpackage

// File: rtl/id_ex_elastic.sv
// rtl/id_ex_elastic.sv - ID/EX wrapper packing named fields around one elastic stage
//
// Ports:
//   clk, rst, i_flush                    clock, synchronous active-high reset, flush
//   i_id_valid/o_id_ready, i_id_*        decode-side handshake and fields
//   o_ex_valid/i_ex_ready, o_ex_*        execute-side handshake and fields (NOP fields when empty)
//   i_next_in_ds/o_next_in_ds            next-instruction-in-delay-slot flag in/out
//   o_bubble_cnt, o_occupancy            stage statistics
module id_ex_elastic
    import pipe_stage_elastic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_id_valid,
    output logic        o_id_ready,
    input  logic [7:0]  i_id_aluop,
    input  logic [2:0]  i_id_alusel,
    input  logic [31:0] i_id_reg1,
    input  logic [31:0] i_id_reg2,
    input  logic [4:0]  i_id_wd,
    input  logic        i_id_wreg,
    input  logic [31:0] i_id_link,
    input  logic        i_id_in_ds,
    input  logic        i_next_in_ds,
    output logic        o_ex_valid,
    input  logic        i_ex_ready,
    output logic [7:0]  o_ex_aluop,
    output logic [2:0]  o_ex_alusel,
    output logic [31:0] o_ex_reg1,
    output logic [31:0] o_ex_reg2,
    output logic [4:0]  o_ex_wd,
    output logic        o_ex_wreg,
    output logic [31:0] o_ex_link,
    output logic        o_ex_in_ds,
    output logic        o_next_in_ds,
    output logic [15:0] o_bubble_cnt,
    output logic [1:0]  o_occupancy
);

    logic [IDEX_W-1:0] w_in_data;
    logic [IDEX_W-1:0] w_out_data;

    assign w_in_data = {i_id_aluop, i_id_alusel, i_id_reg1, i_id_reg2,
                        i_id_wd, i_id_wreg, i_id_link, i_id_in_ds};

    assign o_ex_aluop  = w_out_data[IDEX_ALUOP_LSB  +: IDEX_ALUOP_W];
    assign o_ex_alusel = w_out_data[IDEX_ALUSEL_LSB +: IDEX_ALUSEL_W];
    assign o_ex_reg1   = w_out_data[IDEX_REG1_LSB   +: IDEX_REG_W];
    assign o_ex_reg2   = w_out_data[IDEX_REG2_LSB   +: IDEX_REG_W];
    assign o_ex_wd     = w_out_data[IDEX_WD_LSB     +: IDEX_WD_W];
    assign o_ex_wreg   = w_out_data[IDEX_WREG_LSB];
    assign o_ex_link   = w_out_data[IDEX_LINK_LSB   +: IDEX_LINK_W];
    assign o_ex_in_ds  = w_out_data[IDEX_DS_LSB];

    pipe_stage_elastic #(
        .DATA_W    (IDEX_W),
        .NOP_VALUE (128'(IDEX_NOP)),
        .CNT_W     (16)
    ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (i_flush),
        .in_valid   (i_id_valid),
        .in_ready   (o_id_ready),
        .in_data    (w_in_data),
        .in_ds_next (i_next_in_ds),
        .out_valid  (o_ex_valid),
        .out_ready  (i_ex_ready),
        .out_data   (w_out_data),
        .ds_next_o  (o_next_in_ds),
        .bubble_cnt (o_bubble_cnt),
        .occupancy  (o_occupancy)
    );

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline register with 2-entry skid buffer
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           kills all held entries and clears the delay-slot sideband
//   in_valid/in_ready/in_data/in_ds_next   upstream handshake, payload, delay-slot flag
//   out_valid/out_ready/out_data           downstream handshake, head payload (NOP when empty)
//   ds_next_o       last accepted in_ds_next
//   bubble_cnt      saturating count of cycles downstream was ready but the stage empty
//   occupancy       number of valid entries 0..2
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int           DATA_W    = 114,
    parameter logic [127:0] NOP_VALUE = 128'h0,
    parameter int           CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_ds_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ds_next_o,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [1:0]        occupancy
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_VALUE);

    occ_e              r_state;
    occ_e              w_state_nxt;
    logic [DATA_W-1:0] r_head_data;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_ds_next;
    logic [CNT_W-1:0]  r_bubble;

    logic              w_accept;
    logic              w_drain;
    logic              w_head_load;
    logic [DATA_W-1:0] w_head_nxt;
    logic              w_skid_load;
    logic [DATA_W-1:0] w_skid_nxt;

    // in_ready comes only from the state register, so there is no path from out_ready.
    assign in_ready   = (r_state != OCC_FULL);
    assign out_valid  = (r_state != OCC_EMPTY);
    assign out_data   = r_head_data;
    assign occupancy  = r_state;
    assign ds_next_o  = r_ds_next;
    assign bubble_cnt = r_bubble;

    assign w_accept = in_valid & in_ready & ~flush;
    assign w_drain  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_load = 1'b0;
        w_head_nxt  = NOP;
        w_skid_load = 1'b0;
        w_skid_nxt  = NOP;
        case (r_state)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = OCC_ONE;
                    w_head_load = 1'b1;
                    w_head_nxt  = in_data;
                end
            end
            OCC_ONE: begin
                if (w_accept && w_drain) begin
                    w_head_load = 1'b1;
                    w_head_nxt  = in_data;
                end else if (w_accept) begin
                    w_state_nxt = OCC_FULL;
                    w_skid_load = 1'b1;
                    w_skid_nxt  = in_data;
                end else if (w_drain) begin
                    // Head returns to NOP so out_data needs no output mux.
                    w_state_nxt = OCC_EMPTY;
                    w_head_load = 1'b1;
                end
            end
            OCC_FULL: begin
                if (w_drain) begin
                    w_state_nxt = OCC_ONE;
                    w_head_load = 1'b1;
                    w_head_nxt  = r_skid_data;
                    w_skid_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = OCC_EMPTY;
                w_head_load = 1'b1;
                w_skid_load = 1'b1;
            end
        endcase
        if (flush) begin
            w_state_nxt = OCC_EMPTY;
            w_head_load = 1'b1;
            w_head_nxt  = NOP;
            w_skid_load = 1'b1;
            w_skid_nxt  = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_data <= NOP;
            r_skid_data <= NOP;
        end else begin
            if (w_head_load) begin
                r_head_data <= w_head_nxt;
            end
            if (w_skid_load) begin
                r_skid_data <= w_skid_nxt;
            end
        end
    end

    // Sideband survives bubbles; only an accept, flush or reset changes it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ds_next <= 1'b0;
        end else if (w_accept) begin
            r_ds_next <= in_ds_next;
        end
    end

    // Flush does not clear the counter; it only suppresses counting in its cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble <= '0;
        end else if (out_ready && !out_valid && !flush && (r_bubble != {CNT_W{1'b1}})) begin
            r_bubble <= r_bubble + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline stage register. It is the successor to the fixed ID/EX register and replaces the global stall-vector scheme with a per-stage valid/ready handshake. It holds a 2-entry skid buffer so that upstream ready is registered and never combinationally depends on out_ready. It also adds flush, NOP injection, a carried "next-is-delay-slot" sideband and a bubble counter. It is instantiated between any two CPU stages, starting with ID to EX.

Parameters:
DATA_W, 114, payload width (aluop 8 + alusel 3 + reg1 32 + reg2 32 + wd 5 + wreg 1 + link 32 + in_delayslot 1).
NOP_VALUE, 0, payload driven on out_data when the stage is empty; truncated/zero-extended to DATA_W.
CNT_W, 16, bubble counter width.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream has a payload
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_data  in  DATA_W  upstream payload
in_ds_next  in  1  upstream flag: the next instruction is in a delay slot
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head this cycle
out_data  out  DATA_W  head payload, or NOP_VALUE when !out_valid
ds_next_o  out  1  last accepted in_ds_next
bubble_cnt  out  CNT_W  saturating count of starved cycles
occupancy  out  2  number of valid entries, 0..2

Behaviour:
- Definitions: accept = in_valid & in_ready & !flush; drain = out_valid & out_ready & !flush.
- Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle with no bubbles while out_ready stays high.
- Storage: head (valid, data) and skid (valid, data). Outputs are driven from head only.
- State machine, encoded by occupancy:
  - EMPTY(0): accept -> ONE, head <= in_data.
  - ONE(1):
    - accept & drain -> ONE, head <= in_data.
    - accept & !drain -> FULL, skid <= in_data.
    - !accept & drain -> EMPTY, head data <= NOP_VALUE.
    - otherwise hold.
  - FULL(2): in_ready = 0, so no accept is possible. drain -> ONE, head <= skid, skid data <= NOP_VALUE. Otherwise hold.
- Ordering: data leaves in acceptance order. The skid entry never overtakes the head.
- ds_next_o:
  - Loads in_ds_next on every accept.
  - Holds through empty cycles; it is not cleared by bubbles.
  - Cleared by rst and by flush.
- flush:
  - Priority is below rst and above everything else.
  - Next cycle: occupancy = 0, both data fields = NOP_VALUE, ds_next_o = 0, in_ready = 1.
  - Any in_valid presented in the flush cycle is dropped, even though in_ready was 1.
- bubble_cnt: increments when out_ready & !out_valid & !flush. Saturates at all-ones with no wrap. Cleared only by rst; flush does not clear it.
- Reset values: out_valid = 0, out_data = NOP_VALUE, in_ready = 1, ds_next_o = 0, bubble_cnt = 0, occupancy = 0. Skid data = NOP_VALUE.
- Reset mid-operation: all entries are discarded regardless of state. No transfer completes in the reset cycle.
- in_ready is derived only from registered state; it has no combinational path from out_ready.
- out_data is a pure register output and is glitch-free.

Decomposition:
- Shared package/defines:
  - NOP encodings (EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr, ZeroWord).
  - Delay-slot constants.
  - ID/EX payload field offsets and widths, so that DATA_W and NOP_VALUE for each instantiation are computed there.
  - Occupancy encodings (OCC_EMPTY/ONE/FULL).
- No sub-module; the two entries are flat registers.
- A thin id_ex_elastic wrapper packs and unpacks the named ID/EX fields around one instance.

Test Plan:
1. Streaming (DATA_W=8, NOP_VALUE=8'h00). After reset, drive in_valid=1 with data 8'h11, 8'h22, 8'h33 on consecutive cycles, out_ready=1 -> out_data 11,22,33 one cycle later each; in_ready stays 1; bubble_cnt stays 0.
2. Backpressure fill. Accept 8'hA1, then hold out_ready=0 and offer 8'hA2, then 8'hA3 -> occupancy goes 1, 2; in_ready drops to 0; A3 is held upstream. Raise out_ready -> outputs A1, A2, A3 in order with no loss or duplication.
3. Flush while FULL, with in_valid=1 carrying 8'h55 in the flush cycle -> next cycle out_valid=0, out_data=00, occupancy=0, ds_next_o=0; 55 never appears on out_data.
4. Delay-slot sideband. Accept a payload with in_ds_next=1, then idle 3 cycles -> ds_next_o stays 1 through the bubbles. Accept a payload with in_ds_next=0 -> ds_next_o goes to 0 the next cycle.
5. Bubble saturation (CNT_W=2). Hold in_valid=0 and out_ready=1 for 6 cycles -> bubble_cnt reads 1, 2, 3, 3, 3, 3. Assert flush -> count stays 3. Assert rst -> count reads 0.
6. Reset mid-operation. Assert rst while FULL with out_ready=1 -> next cycle all outputs are at reset values; neither entry is delivered.
